// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - tenths-of-a-second BCD stopwatch (00.0-59.9) fed by a 10 Hz tick; optional wrap via STOPWATCH_WRAP_EN
module stopwatch_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       slow_clk,
  input  logic       start_stop,
  input  logic       clear,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] tenths,
  output logic       running,
  output logic       at_max
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;
  logic                   tick;
  state_t                 state_q, state_d;
  logic [2:0]             tens_q, tens_d;
  logic [3:0]             ones_q, ones_d;
  logic [3:0]             tenths_q, tenths_d;
  logic                   running_q, running_d;
  logic                   at_max_q, at_max_d;
  logic                   count_max;

  // Synchronize slow_clk as data and detect its rising edge.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], slow_clk};
    edge_d = sync_q[SYNC_STAGES-1];
    tick   = sync_q[SYNC_STAGES-1] & ~edge_q;
  end

  assign count_max = (tens_q == 3'd5) && (ones_q == 4'd9) && (tenths_q == 4'd9);

  // Next state and next count; clear overrides everything, ticks outside RUN are dropped.
  always_comb begin
    state_d  = state_q;
    tens_d   = tens_q;
    ones_d   = ones_q;
    tenths_d = tenths_q;
    if (clear) begin
      state_d  = IDLE;
      tens_d   = 3'd0;
      ones_d   = 4'd0;
      tenths_d = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_stop) state_d = RUN;
        end
        RUN: begin
          if (tick) begin
            if (count_max) begin
`ifdef STOPWATCH_WRAP_EN
              tens_d   = 3'd0;
              ones_d   = 4'd0;
              tenths_d = 4'd0;
`else
              state_d  = PAUSE;
`endif
            end else if (tenths_q == 4'd9) begin
              tenths_d = 4'd0;
              if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = tens_q + 3'd1;
              end else begin
                ones_d = ones_q + 4'd1;
              end
            end else begin
              tenths_d = tenths_q + 4'd1;
            end
          end
          if (start_stop) state_d = PAUSE;
        end
        PAUSE: begin
`ifdef STOPWATCH_WRAP_EN
          if (start_stop) state_d = RUN;
`else
          // A count held at 59.9 stays frozen until clear.
          if (start_stop && !count_max) state_d = RUN;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
    running_d = (state_d == RUN);
    at_max_d  = (tens_d == 3'd5) && (ones_d == 4'd9) && (tenths_d == 4'd9);
  end

  // All state and outputs registered; reset clears them immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      edge_q    <= 1'b0;
      state_q   <= IDLE;
      tens_q    <= 3'd0;
      ones_q    <= 4'd0;
      tenths_q  <= 4'd0;
      running_q <= 1'b0;
      at_max_q  <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      edge_q    <= edge_d;
      state_q   <= state_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      tenths_q  <= tenths_d;
      running_q <= running_d;
      at_max_q  <= at_max_d;
    end
  end

  assign sec_tens = tens_q;
  assign sec_ones = ones_q;
  assign tenths   = tenths_q;
  assign running  = running_q;
  assign at_max   = at_max_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl with a behavioural tenths-count model
module tb_stopwatch_ctrl;

  localparam int SS = 2;
`ifdef STOPWATCH_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       slow_clk = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic [2:0] sec_tens;
  logic [3:0] sec_ones;
  logic [3:0] tenths;
  logic       running;
  logic       at_max;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: elapsed time in tenths, mode 0=idle 1=run 2=pause, history of sampled slow_clk.
  int m_cnt = 0;
  int m_mode = 0;
  bit hist [0:SS];

  stopwatch_ctrl #(.SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .slow_clk(slow_clk), .start_stop(start_stop), .clear(clear),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .tenths(tenths), .running(running), .at_max(at_max)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // A tick is counted on the edge where slow_clk was seen high SS edges ago and low SS+1 edges ago.
  initial begin
    for (int i = 0; i <= SS; i++) hist[i] = 1'b0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_cnt = 0;
        m_mode = 0;
        for (int i = 0; i <= SS; i++) hist[i] = 1'b0;
      end else begin
        bit tk;
        tk = hist[SS-1] && !hist[SS];
        for (int i = SS; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = slow_clk;
        if (clear) begin
          m_mode = 0;
          m_cnt = 0;
        end else if (m_mode == 0) begin
          if (start_stop) m_mode = 1;
        end else if (m_mode == 1) begin
          if (tk) begin
            if (m_cnt == 599) begin
              if (WRAP) m_cnt = 0;
              else m_mode = 2;
            end else begin
              m_cnt = m_cnt + 1;
            end
          end
          if (start_stop) m_mode = 2;
        end else begin
          if (start_stop && !(m_cnt == 599 && !WRAP)) m_mode = 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("model sec_tens", int'(sec_tens), m_cnt / 100);
      chk("model sec_ones", int'(sec_ones), (m_cnt / 10) % 10);
      chk("model tenths", int'(tenths), m_cnt % 10);
      chk("model running", int'(running), int'(m_mode == 1));
      chk("model at_max", int'(at_max), int'(m_cnt == 599));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic give_tick();
    slow_clk = 1'b1;
    repeat (3) cyc();
    slow_clk = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic ticks(input int n);
    repeat (n) give_tick();
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    cyc();
    start_stop = 1'b0;
  endtask

  task automatic expect_now(input string nm, input int t, input int o, input int te, input int run, input int mx);
    chk({nm, " tens"}, int'(sec_tens), t);
    chk({nm, " ones"}, int'(sec_ones), o);
    chk({nm, " tenths"}, int'(tenths), te);
    chk({nm, " running"}, int'(running), run);
    chk({nm, " at_max"}, int'(at_max), mx);
  endtask

  task automatic expect_lit(input string nm, input int t, input int o, input int te, input int run, input int mx);
    @(negedge clk);
    expect_now(nm, t, o, te, run, mx);
    cyc();
  endtask

  initial begin
    #2 rst = 1'b1;
    #1 expect_now("reset", 0, 0, 0, 0, 0);
    cyc();
    cyc();
    rst = 1'b0;
    chk_en = 1'b1;
    expect_lit("after reset", 0, 0, 0, 0, 0);

    // Count to 12.3, then asynchronous reset mid-cycle.
    pulse_ss();
    ticks(123);
    expect_lit("at 12.3", 1, 2, 3, 1, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 expect_now("async reset", 0, 0, 0, 0, 0);
    cyc();
    cyc();
    rst = 1'b0;
    ticks(20);
    expect_lit("idle ignores ticks", 0, 0, 0, 0, 0);

    // Tick latency: increment lands on the (SS+1)th edge after slow_clk rises.
    pulse_ss();
    slow_clk = 1'b1;
    repeat (SS) @(posedge clk);
    @(negedge clk);
    chk("latency before", int'(tenths), 0);
    @(posedge clk);
    @(negedge clk);
    chk("latency after", int'(tenths), 1);
    cyc();
    slow_clk = 1'b0;
    repeat (3) cyc();
    ticks(24);
    expect_lit("at 02.5", 0, 2, 5, 1, 0);

    // start_stop coinciding with the tick at 03.4.
    ticks(9);
    slow_clk = 1'b1;
    repeat (SS) @(posedge clk);
    #1 start_stop = 1'b1;
    cyc();
    start_stop = 1'b0;
    expect_lit("pause with tick", 0, 3, 5, 0, 0);
    cyc();
    slow_clk = 1'b0;
    repeat (3) cyc();
    ticks(10);
    expect_lit("paused holds", 0, 3, 5, 0, 0);
    pulse_ss();
    give_tick();
    expect_lit("resume", 0, 3, 6, 1, 0);

    // clear and start_stop together at 41.7.
    ticks(381);
    expect_lit("at 41.7", 4, 1, 7, 1, 0);
    clear = 1'b1;
    start_stop = 1'b1;
    cyc();
    clear = 1'b0;
    start_stop = 1'b0;
    expect_lit("clear wins", 0, 0, 0, 0, 0);

    // Full carry chain and the 59.9 boundary.
    pulse_ss();
    ticks(599);
    expect_lit("at 59.9", 5, 9, 9, 1, 1);
    give_tick();
    if (WRAP) begin
      expect_lit("wrap", 0, 0, 0, 1, 0);
    end else begin
      expect_lit("hold at max", 5, 9, 9, 0, 1);
      pulse_ss();
      expect_lit("start ignored at max", 5, 9, 9, 0, 1);
    end
    clear = 1'b1;
    cyc();
    clear = 1'b0;

    // Random traffic checked by the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) slow_clk = ~slow_clk;
      start_stop = ($urandom_range(0, 19) == 0);
      clear = ($urandom_range(0, 199) == 0);
      cyc();
    end
    start_stop = 1'b0;
    clear = 1'b0;
    cyc();
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Tenths-of-a-second stopwatch core that sits directly downstream of the 10 Hz frequency divider. It samples the divider's slow square wave in the system clock domain, turns each rising edge into a one-cycle tick, and runs a BCD counter 00.0–59.9 under start/stop and clear control. Its BCD digit outputs feed the seven-segment scan stage.

## Interface
- SYNC_STAGES, 2: synchronizer flops on `slow_clk`; legal range ≥ 2.

- clk  input  1  system clock, 100 MHz; every flop in the block is clocked on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- slow_clk  input  1  10 Hz square wave from the frequency divider; treated as data, never used as a clock.
- start_stop  input  1  single-cycle pulse, already debounced; toggles run/pause.
- clear  input  1  single-cycle pulse; returns the count to 00.0 and the FSM to IDLE.
- sec_tens  output  3  BCD seconds tens digit, 0–5.
- sec_ones  output  4  BCD seconds ones digit, 0–9.
- tenths  output  4  BCD tenths digit, 0–9.
- running  output  1  high while in RUN.
- at_max  output  1  high while the count equals 59.9.

## Operation
- **Tick generation.**
  - `slow_clk` passes through SYNC_STAGES flops, then a one-flop edge register.
  - `tick` = synchronized value high AND edge register low.
  - At 10 Hz this gives exactly one tick per 10,000,000 clk cycles.
- **FSM states:** IDLE, RUN, PAUSE. All outputs come from registers.
- **Transitions:**
  - IDLE + start_stop → RUN.
  - RUN + start_stop → PAUSE.
  - PAUSE + start_stop → RUN, unless at_max is high and STOPWATCH_WRAP_EN is undefined; then it stays in PAUSE.
  - Any state + clear → IDLE, with the count set to 00.0.
- **Counting.**
  - The count advances only on a tick while in RUN.
  - tenths 9→0 carries into sec_ones; sec_ones 9→0 carries into sec_tens.
  - At 59.9 the behaviour is set by STOPWATCH_WRAP_EN (see Configuration).
  - Ticks in IDLE and PAUSE are discarded, not queued.
- **Simultaneous events.**
  - clear with start_stop: clear wins, result is IDLE at 00.0.
  - clear with tick: clear wins.
  - start_stop with tick in RUN: the count increments and the FSM goes to PAUSE in the same edge.
  - start_stop with tick in PAUSE: the FSM goes to RUN; the tick is not counted.
- **Reset.**
  - Synchronizer flops and edge register = 0.
  - FSM = IDLE.
  - All digits = 0, `running` = 0, `at_max` = 0.
  - Reset mid-run discards the count immediately; there is no resume.
  - If `slow_clk` is high when reset is released, one spurious tick is produced. It is harmless because the FSM is in IDLE.

## Timing
- **Tick latency:** `tick` is high for exactly one cycle, SYNC_STAGES+1 clk edges after the first edge that samples `slow_clk` high.
- **Count update:** digits change on the edge where `tick` is high in RUN, and are visible the following cycle.
- **running:** updates on the same edge as the FSM state; `start_stop` at edge N gives `running` = 1 after edge N.
- **at_max:** registered; rises in the same cycle the digits show 59.9.
- **Control inputs:** no handshake; each pulse is consumed on the edge where it is sampled high. A pulse longer than one cycle is treated as multiple pulses.

## Configuration
- **STOPWATCH_WRAP_EN defined:**
  - In RUN, a tick at 59.9 gives 00.0.
  - The FSM stays in RUN.
  - `at_max` drops with the wrap.
- **STOPWATCH_WRAP_EN undefined:**
  - In RUN, a tick at 59.9 holds the count at 59.9 and forces PAUSE.
  - `start_stop` is ignored until `clear`.

## Test plan
- **Reset values:** assert `rst` mid-count at 12.3 → all outputs are 0 within the same cycle, with no clk edge needed. After release and 20 ticks without `start_stop`, digits remain 00.0.
- **Run and tick latency:** pulse `start_stop`, then apply 25 `slow_clk` rising edges → digits 02.5, `running` = 1. Each increment lands SYNC_STAGES+1 edges after the `slow_clk` rise.
- **Pause:** pulse `start_stop` in the same cycle as a tick at 03.4 → count shows 03.5 and the FSM is in PAUSE. A further 10 ticks leave 03.5. Pulsing `start_stop` again resumes counting.
- **clear priority:** pulse `clear` and `start_stop` together during RUN at 41.7 → 00.0, IDLE, `running` = 0.
- **Carry chain:** 599 ticks from 00.0 → 59.9 with `at_max` = 1, and every intermediate 9→0 carry is correct.
- **Boundary at 59.9:**
  - Without the macro: one more tick → 59.9 held, PAUSE, and `start_stop` is ignored.
  - With STOPWATCH_WRAP_EN: one more tick → 00.0, still RUN, `at_max` = 0.
